// File: rtl/sram_axi_pkg.sv
// Shared definitions for the sram_axi responder: response codes, FSM encoding,
// default base address and the byte-merge helper used by the storage bank.
package sram_axi_pkg;

    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [1:0]  RESP_SLVERR   = 2'b10;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h8000_0000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_RD_RESP = 3'd2,
        ST_WR_WAIT = 3'd3,
        ST_WR_RESP = 3'd4
    } state_t;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_axi_bank.sv
// Word-organised storage with per-byte write enables and a combinational read port.
// Contents are deliberately not reset.
module sram_bank
    import sram_axi_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clock,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [3:0]    i_wstrb,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    // byte-enabled write port
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= byte_merge(r_mem[i_waddr], i_wdata, i_wstrb);
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sram_axi.sv
// AXI4-Lite responder over sram_bank: one outstanding transaction, alternating
// read/write arbitration, fixed response latency and address range checking.
module sram_axi
    import sram_axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [32:0] LIMIT    = {1'b0, BASE_ADDR} + (33'(DEPTH) << 2);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    state_t         r_state, w_nx_state;
    logic [CW-1:0]  r_cnt, w_nx_cnt;
    logic           r_wr_prio;
    logic           r_rvalid, r_bvalid;
    logic [31:0]    r_rdata, r_cap_data;
    logic [1:0]     r_rresp, r_bresp, r_cap_resp;
    logic           w_grant_rd, w_grant_wr;
    logic           w_rd_in_range, w_wr_in_range;
    logic [AW-1:0]  w_rd_idx, w_wr_idx;
    logic [31:0]    w_bank_rdata, w_rd_word;
    logic [1:0]     w_rd_code, w_wr_code;

    // 33-bit compare so the window cannot wrap past 4 GiB
    function automatic logic in_range(input logic [31:0] a);
        return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < LIMIT);
    endfunction

    assign w_rd_in_range = in_range(araddr);
    assign w_wr_in_range = in_range(awaddr);
    assign w_rd_idx      = AW'((araddr - BASE_ADDR) >> 2'd2);
    assign w_wr_idx      = AW'((awaddr - BASE_ADDR) >> 2'd2);
    assign w_rd_word     = w_rd_in_range ? w_bank_rdata : 32'h0;
    assign w_rd_code     = w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
    assign w_wr_code     = w_wr_in_range ? RESP_OKAY : RESP_SLVERR;

    sram_bank #(.DEPTH(DEPTH), .AW(AW)) u_bank (
        .clock   (clock),
        .i_we    (w_grant_wr & w_wr_in_range),
        .i_waddr (w_wr_idx),
        .i_wdata (wdata),
        .i_wstrb (wstrb),
        .i_raddr (w_rd_idx),
        .o_rdata (w_bank_rdata)
    );

    // next-state, latency counter and grant decode; grants are held off while in reset
    always_comb begin
        w_nx_state = r_state;
        w_nx_cnt   = r_cnt;
        w_grant_rd = 1'b0;
        w_grant_wr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (reset && arvalid && !(awvalid && wvalid && r_wr_prio)) begin
                    w_grant_rd = 1'b1;
                    w_nx_cnt   = CNT_LOAD;
                    w_nx_state = (LATENCY == 1) ? ST_RD_RESP : ST_RD_WAIT;
                end else if (reset && awvalid && wvalid) begin
                    w_grant_wr = 1'b1;
                    w_nx_cnt   = CNT_LOAD;
                    w_nx_state = (LATENCY == 1) ? ST_WR_RESP : ST_WR_WAIT;
                end else begin
                    w_nx_state = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (r_cnt == {CW{1'b0}}) w_nx_state = ST_RD_RESP;
                else                     w_nx_cnt   = r_cnt - CW'(1);
            end
            ST_WR_WAIT: begin
                if (r_cnt == {CW{1'b0}}) w_nx_state = ST_WR_RESP;
                else                     w_nx_cnt   = r_cnt - CW'(1);
            end
            ST_RD_RESP: begin
                if (rready) w_nx_state = ST_IDLE;
                else        w_nx_state = ST_RD_RESP;
            end
            ST_WR_RESP: begin
                if (bready) w_nx_state = ST_IDLE;
                else        w_nx_state = ST_WR_RESP;
            end
            default: begin
                w_nx_state = ST_IDLE;
                w_nx_cnt   = {CW{1'b0}};
            end
        endcase
    end

    // state and counter registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= {CW{1'b0}};
        end else begin
            r_state <= w_nx_state;
            r_cnt   <= w_nx_cnt;
        end
    end

    // arbitration priority, handshake capture and registered response channels
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_prio  <= 1'b0;
            r_cap_data <= 32'h0;
            r_cap_resp <= RESP_OKAY;
            r_rvalid   <= 1'b0;
            r_rdata    <= 32'h0;
            r_rresp    <= RESP_OKAY;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
        end else begin
            if (w_grant_rd) begin
                r_wr_prio  <= 1'b1;
                r_cap_data <= w_rd_word;
                r_cap_resp <= w_rd_code;
            end else if (w_grant_wr) begin
                r_wr_prio  <= 1'b0;
                r_cap_resp <= w_wr_code;
            end
            if (w_nx_state == ST_RD_RESP && r_state != ST_RD_RESP) begin
                r_rvalid <= 1'b1;
                r_rdata  <= (r_state == ST_IDLE) ? w_rd_word : r_cap_data;
                r_rresp  <= (r_state == ST_IDLE) ? w_rd_code : r_cap_resp;
            end else if (r_state == ST_RD_RESP && rready) begin
                r_rvalid <= 1'b0;
                r_rdata  <= 32'h0;
                r_rresp  <= RESP_OKAY;
            end
            if (w_nx_state == ST_WR_RESP && r_state != ST_WR_RESP) begin
                r_bvalid <= 1'b1;
                r_bresp  <= (r_state == ST_IDLE) ? w_wr_code : r_cap_resp;
            end else if (r_state == ST_WR_RESP && bready) begin
                r_bvalid <= 1'b0;
                r_bresp  <= RESP_OKAY;
            end
        end
    end

    assign arready = w_grant_rd;
    assign awready = w_grant_wr;
    assign wready  = w_grant_wr;
    assign rvalid  = r_rvalid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;

endmodule

// File: tb/tb_sram_axi.sv
// Randomised self-checking bench for sram_axi against a word-array reference model,
// with directed latency, byte-strobe, range, arbitration and reset scenarios.
module tb_sram_axi;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 1024;
    localparam int          LAT   = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;

    logic [31:0] araddr1, rdata1, awaddr1, wdata1;
    logic        arvalid1, arready1, rvalid1, rready1, awvalid1, awready1, wvalid1, wready1, bvalid1, bready1;
    logic [1:0]  rresp1, bresp1;
    logic [3:0]  wstrb1;

    sram_axi #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clock(clk), .reset(reset),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    sram_axi #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clock(clk), .reset(reset),
        .araddr(araddr1), .arvalid(arvalid1), .arready(arready1),
        .rdata(rdata1), .rresp(rresp1), .rvalid(rvalid1), .rready(rready1),
        .awaddr(awaddr1), .awvalid(awvalid1), .awready(awready1),
        .wdata(wdata1), .wstrb(wstrb1), .wvalid(wvalid1), .wready(wready1),
        .bresp(bresp1), .bvalid(bvalid1), .bready(bready1)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mdl_mem [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit mdl_in_range(input logic [31:0] a);
        longint la = longint'(a);
        longint lb = longint'(BASE);
        return (la >= lb) && (la < lb + 4 * DEPTH);
    endfunction

    function automatic int mdl_idx(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) / 4);
    endfunction

    function automatic logic [31:0] mdl_rdata(input logic [31:0] a);
        return mdl_in_range(a) ? mdl_mem[mdl_idx(a)] : 32'h0;
    endfunction

    function automatic logic [1:0] mdl_resp(input logic [31:0] a);
        return mdl_in_range(a) ? 2'b00 : 2'b10;
    endfunction

    function automatic void mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (mdl_in_range(a)) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) mdl_mem[mdl_idx(a)][8*b +: 8] = d[8*b +: 8];
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb, input int hold);
        logic [1:0] eresp;
        int n;
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        n = 0;
        while (!(awready && wready) && n < 20) begin step(); n++; end
        chk("aw_handshake", {31'b0, awready & wready}, 32'd1);
        eresp = mdl_resp(addr);
        mdl_write(addr, data, strb);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            chk("b_early", {31'b0, bvalid}, 32'd0);
            chk("b_early_resp", {30'b0, bresp}, 32'd0);
            step();
        end
        chk("b_valid", {31'b0, bvalid}, 32'd1);
        chk("b_resp", {30'b0, bresp}, {30'b0, eresp});
        repeat (hold) begin
            step();
            chk("b_hold", {31'b0, bvalid}, 32'd1);
            chk("b_hold_resp", {30'b0, bresp}, {30'b0, eresp});
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk("b_done", {31'b0, bvalid}, 32'd0);
        chk("b_done_resp", {30'b0, bresp}, 32'd0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int hold);
        logic [31:0] edata;
        logic [1:0]  eresp;
        int n;
        araddr = addr; arvalid = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 20) begin step(); n++; end
        chk("ar_handshake", {31'b0, arready}, 32'd1);
        edata = mdl_rdata(addr);
        eresp = mdl_resp(addr);
        step();
        arvalid = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            chk("r_early", {31'b0, rvalid}, 32'd0);
            chk("r_early_data", rdata, 32'd0);
            step();
        end
        chk("r_valid", {31'b0, rvalid}, 32'd1);
        chk("r_data", rdata, edata);
        chk("r_resp", {30'b0, rresp}, {30'b0, eresp});
        repeat (hold) begin
            step();
            chk("r_hold", {31'b0, rvalid}, 32'd1);
            chk("r_hold_data", rdata, edata);
            chk("r_hold_resp", {30'b0, rresp}, {30'b0, eresp});
        end
        rready = 1'b1;
        step();
        rready = 1'b0;
        chk("r_done", {31'b0, rvalid}, 32'd0);
        chk("r_done_data", rdata, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ed;
        logic [31:0] bnd [5];
        logic        prev;
        logic [31:0] addr;

        reset = 1'b0;
        araddr = 32'h0; arvalid = 1'b0; rready = 1'b0;
        awaddr = 32'h0; awvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0; bready = 1'b0;
        araddr1 = 32'h0; arvalid1 = 1'b0; rready1 = 1'b0;
        awaddr1 = 32'h0; awvalid1 = 1'b0; wdata1 = 32'h0; wstrb1 = 4'h0; wvalid1 = 1'b0; bready1 = 1'b0;
        bnd[0] = 32'h8000_0FFC; bnd[1] = 32'h8000_0FFF; bnd[2] = 32'h8000_1000;
        bnd[3] = 32'h7FFF_FFFC; bnd[4] = 32'hFFFF_FFFC;

        repeat (2) step();
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_bvalid", {31'b0, bvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_arready", {31'b0, arready}, 32'd0);
        reset = 1'b1;
        step();

        for (int i = 0; i < 16; i++) axi_write(BASE + 32'(4 * i), $urandom, 4'hF, 0);
        axi_write(32'h8000_0FFC, $urandom, 4'hF, 0);

        // latency and hold stability
        axi_write(32'h8000_0010, 32'hDEADBEEF, 4'hF, 0);
        axi_read(32'h8000_0010, 3);
        // byte strobes
        axi_write(32'h8000_0040, 32'h11223344, 4'hF, 0);
        axi_write(32'h8000_0040, 32'hAABBCCDD, 4'b0101, 1);
        axi_read(32'h8000_0040, 0);
        // out of range
        axi_write(32'h8000_0000, 32'hCAFEF00D, 4'hF, 0);
        axi_read(32'h8000_1000, 0);
        axi_write(32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 0);
        axi_read(32'h8000_0000, 0);
        for (int i = 0; i < 5; i++) axi_read(bnd[i], 0);

        // reset during RD_WAIT
        araddr = 32'h8000_0010; arvalid = 1'b1;
        #1;
        chk("rst_ar_hs", {31'b0, arready}, 32'd1);
        step();
        arvalid = 1'b0;
        #1;
        reset = 1'b0;
        awaddr = 32'h8000_0010; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        #1;
        chk("rst_mid_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_mid_rdata", rdata, 32'd0);
        chk("rst_mid_rresp", {30'b0, rresp}, 32'd0);
        chk("rst_mid_arready", {31'b0, arready}, 32'd0);
        chk("rst_mid_awready", {31'b0, awready}, 32'd0);
        chk("rst_mid_wready", {31'b0, wready}, 32'd0);
        chk("rst_mid_bvalid", {31'b0, bvalid}, 32'd0);
        chk("rst_mid_bresp", {30'b0, bresp}, 32'd0);
        repeat (3) begin
            step();
            chk("rst_hold_rvalid", {31'b0, rvalid}, 32'd0);
            chk("rst_hold_arready", {31'b0, arready}, 32'd0);
        end
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        reset = 1'b1;
        repeat (3) begin
            step();
            chk("rst_after_rvalid", {31'b0, rvalid}, 32'd0);
        end
        axi_read(32'h8000_0010, 0);

        // arbitration from a fresh reset, all requests held high
        reset = 1'b0;
        step();
        reset = 1'b1;
        araddr = 32'h8000_0010; awaddr = 32'h8000_0010; wdata = 32'h0BAD_F00D; wstrb = 4'hF;
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1; rready = 1'b1; bready = 1'b0;
        #1;
        chk("arb_rd_first", {31'b0, arready}, 32'd1);
        chk("arb_wr_wait", {31'b0, awready}, 32'd0);
        ed = mdl_rdata(32'h8000_0010);
        step();
        for (int k = 0; k < LAT; k++) begin
            chk("arb_r_early", {31'b0, rvalid}, 32'd0);
            chk("arb_aw_blocked", {31'b0, awready}, 32'd0);
            step();
        end
        chk("arb_rvalid", {31'b0, rvalid}, 32'd1);
        chk("arb_rdata", rdata, ed);
        chk("arb_aw_in_r_hs", {31'b0, awready}, 32'd0);
        step();
        chk("arb_rvalid_drop", {31'b0, rvalid}, 32'd0);
        chk("arb_wr_second", {31'b0, awready}, 32'd1);
        chk("arb_ar_lost", {31'b0, arready}, 32'd0);
        mdl_write(32'h8000_0010, 32'h0BAD_F00D, 4'hF);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            chk("arb_b_early", {31'b0, bvalid}, 32'd0);
            chk("arb_ar_wait", {31'b0, arready}, 32'd0);
            step();
        end
        chk("arb_bvalid", {31'b0, bvalid}, 32'd1);
        chk("arb_bresp", {30'b0, bresp}, 32'd0);
        awvalid = 1'b1; wvalid = 1'b1; wdata = 32'h600D_CAFE; bready = 1'b1;
        step();
        bready = 1'b0;
        chk("arb_rd_third", {31'b0, arready}, 32'd1);
        chk("arb_wr_lost", {31'b0, awready}, 32'd0);
        ed = mdl_rdata(32'h8000_0010);
        step();
        arvalid = 1'b0;
        for (int k = 0; k < LAT; k++) step();
        chk("arb_coh_rvalid", {31'b0, rvalid}, 32'd1);
        chk("arb_coh_rdata", rdata, ed);
        step();
        chk("arb_wr_fourth", {31'b0, awready}, 32'd1);
        mdl_write(32'h8000_0010, 32'h600D_CAFE, 4'hF);
        step();
        awvalid = 1'b0; wvalid = 1'b0; rready = 1'b0;
        for (int k = 0; k < LAT; k++) step();
        chk("arb_bvalid2", {31'b0, bvalid}, 32'd1);
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk("arb_b_done", {31'b0, bvalid}, 32'd0);
        axi_read(32'h8000_0010, 0);

        // LATENCY=1 back-to-back reads
        araddr1 = 32'h9000_0000; arvalid1 = 1'b1; rready1 = 1'b1;
        #1;
        prev = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("l1_overlap", {31'b0, arready1 & rvalid1}, 32'd0);
            chk("l1_alternate", {31'b0, rvalid1}, {31'b0, ~prev});
            if (rvalid1) begin
                chk("l1_rresp", {30'b0, rresp1}, 32'd2);
                chk("l1_rdata", rdata1, 32'd0);
            end
            prev = rvalid1;
            step();
        end
        arvalid1 = 1'b0; rready1 = 1'b0;
        chk("l1_no_write", {29'b0, bvalid1, awready1, wready1}, 32'd0);
        chk("l1_bresp", {30'b0, bresp1}, 32'd0);

        // randomised traffic
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) addr = bnd[$urandom_range(0, 4)];
            else addr = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) axi_write(addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
            else axi_read(addr, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
